// File: rtl/histogram_pkg.sv
// Shared definitions for the computeHistogram producer and its peak reader:
// default bin geometry, data widths and the reader FSM encoding.
package histogram_pkg;

  localparam int HP_X_BINS  = 240;
  localparam int HP_Y_BINS  = 180;
  localparam int HP_COUNT_W = 8;
  localparam int HP_IDX_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_COLLECT  = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_WAIT_CLR = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/peak_tracker.sv
// Running maximum over one streamed histogram axis; ties keep the lowest index.
// full reflects the beat count including a beat accepted this cycle.
module peak_tracker #(
  parameter int BINS    = 240,
  parameter int COUNT_W = 8,
  parameter int IDX_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               valid,
  input  logic [COUNT_W-1:0] value,
  input  logic               enable,
  output logic [COUNT_W-1:0] maxCount,
  output logic [IDX_W-1:0]   maxIndex,
  output logic               full,
  output logic               overrun
);

  localparam logic [IDX_W:0] BINS_C = (IDX_W+1)'(BINS);

  logic [IDX_W:0]     cnt_q, cnt_d;
  logic [COUNT_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  always_comb begin
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    overrun = 1'b0;
    if (init) begin
      cnt_d = '0;
      max_d = '0;
      idx_d = '0;
    end else if (enable && valid) begin
      if (cnt_q == BINS_C) begin
        overrun = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (value > max_q) begin
          max_d = value;
          idx_d = cnt_q[IDX_W-1:0];
        end else begin
          max_d = max_q;
        end
      end
    end else begin
      overrun = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      max_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign full     = (cnt_d == BINS_C);
  assign maxCount = max_q;
  assign maxIndex = idx_q;

endmodule

// File: rtl/histogram_peak_reader.sv
// Reads one X/Y histogram from the producer, finds each axis peak, then clears
// the producer and publishes registered peak coordinates with a done pulse.
module histogram_peak_reader
  import histogram_pkg::*;
#(
  parameter int X_BINS    = HP_X_BINS,
  parameter int Y_BINS    = HP_Y_BINS,
  parameter int COUNT_W   = HP_COUNT_W,
  parameter int IDX_W     = HP_IDX_W,
  parameter int MIN_COUNT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] xHistogramIn,
  input  logic [COUNT_W-1:0] yHistogramIn,
  input  logic               xValid,
  input  logic               yValid,
  input  logic               histogramClear,
  output logic               readHistogram,
  output logic               clearHistogram,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   xPeakIndex,
  output logic [IDX_W-1:0]   yPeakIndex,
  output logic [COUNT_W-1:0] xPeakCount,
  output logic [COUNT_W-1:0] yPeakCount,
  output logic               found,
  output logic               error
);

  state_e state_q, state_d;

  logic               accept_s, collect_s, bad_s;
  logic               x_full_s, y_full_s, x_over_s, y_over_s;
  logic [COUNT_W-1:0] x_max_s, y_max_s;
  logic [IDX_W-1:0]   x_idx_s, y_idx_s;

  logic               read_q, read_d, clear_q, clear_d, busy_q, busy_d, done_q, done_d;
  logic               found_q, found_d, error_q, error_d;
  logic [IDX_W-1:0]   x_idx_q, x_idx_d, y_idx_q, y_idx_d;
  logic [COUNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;

  assign accept_s  = (state_q == ST_IDLE) && start;
  assign collect_s = (state_q == ST_COLLECT);

  peak_tracker #(.BINS(X_BINS), .COUNT_W(COUNT_W), .IDX_W(IDX_W)) u_x_tracker (
    .clk(clk), .reset(reset), .init(accept_s), .valid(xValid), .value(xHistogramIn),
    .enable(collect_s), .maxCount(x_max_s), .maxIndex(x_idx_s), .full(x_full_s),
    .overrun(x_over_s)
  );

  peak_tracker #(.BINS(Y_BINS), .COUNT_W(COUNT_W), .IDX_W(IDX_W)) u_y_tracker (
    .clk(clk), .reset(reset), .init(accept_s), .valid(yValid), .value(yHistogramIn),
    .enable(collect_s), .maxCount(y_max_s), .maxIndex(y_idx_s), .full(y_full_s),
    .overrun(y_over_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start ? ST_REQ : ST_IDLE;
      ST_REQ:      state_d = ST_COLLECT;
      ST_COLLECT:  state_d = (x_full_s && y_full_s) ? ST_CLEAR : ST_COLLECT;
      ST_CLEAR:    state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: state_d = histogramClear ? ST_DONE : ST_WAIT_CLR;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // An accepted start clears error first so a same-cycle stray beat still flags it.
  assign bad_s = (start && (state_q != ST_IDLE)) ||
                 ((xValid || yValid) && !collect_s) || x_over_s || y_over_s;

  always_comb begin
    read_d  = (state_d == ST_REQ);
    clear_d = (state_d == ST_CLEAR);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    error_d = error_q;
    if (accept_s) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
    if (bad_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_d;
    end
    x_idx_d = x_idx_q;
    y_idx_d = y_idx_q;
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    found_d = found_q;
    if (state_d == ST_DONE) begin
      x_idx_d = x_idx_s;
      y_idx_d = y_idx_s;
      x_cnt_d = x_max_s;
      y_cnt_d = y_max_s;
      found_d = (x_max_s >= COUNT_W'(MIN_COUNT)) && (y_max_s >= COUNT_W'(MIN_COUNT));
    end else begin
      found_d = found_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      found_q <= 1'b0;
      x_idx_q <= '0;
      y_idx_q <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      found_q <= found_d;
      x_idx_q <= x_idx_d;
      y_idx_q <= y_idx_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end

  assign readHistogram  = read_q;
  assign clearHistogram = clear_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign found          = found_q;
  assign xPeakIndex     = x_idx_q;
  assign yPeakIndex     = y_idx_q;
  assign xPeakCount     = x_cnt_q;
  assign yPeakCount     = y_cnt_q;

endmodule

// File: doc/histogram_peak_reader.md
# histogram_peak_reader

Consumer at the read end of the computeHistogram interface. On `start` it issues `readHistogram`, accepts the streamed X bins (`xValid`) and Y bins (`yValid`), and tracks the peak count and peak index of each axis. It then issues `clearHistogram` and waits for the `histogramClear` acknowledge. The registered peak coordinates go to the downstream tracking and filter logic.

## Interface
- `X_BINS`, 240, number of X bins expected per read
- `Y_BINS`, 180, number of Y bins expected per read
- `COUNT_W`, 8, width of one histogram bin value
- `IDX_W`, 8, width of a bin index; must satisfy 2^IDX_W ≥ max(X_BINS, Y_BINS)
- `MIN_COUNT`, 1, minimum peak count for an axis to be reported as found

- `clk` input 1: system clock
- `reset` input 1: asynchronous, active-high reset
- `start` input 1: one-cycle request to begin a read/peak/clear cycle
- `xHistogramIn` input COUNT_W: X bin value, qualified by `xValid`
- `yHistogramIn` input COUNT_W: Y bin value, qualified by `yValid`
- `xValid` input 1: X bin beat valid
- `yValid` input 1: Y bin beat valid
- `histogramClear` input 1: producer acknowledge that its bins are cleared
- `readHistogram` output 1: one-cycle read request to the producer
- `clearHistogram` output 1: one-cycle clear request to the producer
- `busy` output 1: high in every state except IDLE
- `done` output 1: one-cycle pulse; result outputs are valid from this cycle on
- `xPeakIndex` output IDX_W: X bin index of the maximum
- `yPeakIndex` output IDX_W: Y bin index of the maximum
- `xPeakCount` output COUNT_W: X maximum count
- `yPeakCount` output COUNT_W: Y maximum count
- `found` output 1: high when both xPeakCount ≥ MIN_COUNT and yPeakCount ≥ MIN_COUNT
- `error` output 1: sticky protocol error; cleared by the next accepted `start`

## Operation
- The FSM has six states: IDLE → REQ → COLLECT → CLEAR → WAIT_CLR → DONE → IDLE.
- **IDLE:** `start` is accepted and moves to REQ. On acceptance, the per-axis beat counters, running maxima, indices and `error` are cleared.
- **REQ:** `readHistogram` = 1 for exactly this one cycle. Next state is COLLECT.
- **COLLECT:** Each `xValid` beat is assigned beat number n = xBeatCount, and the count increments.
  - If `xHistogramIn` > running max (strictly greater), max ← value and index ← n.
  - Ties therefore keep the lowest index. Y is handled identically and independently.
  - X and Y beats may arrive interleaved, simultaneously or sequentially.
  - Leave for CLEAR when xBeatCount == X_BINS and yBeatCount == Y_BINS, including on the cycle in which the last beat is counted.
- **CLEAR:** `clearHistogram` = 1 for exactly this one cycle. Next state is WAIT_CLR.
- **WAIT_CLR:** Wait for `histogramClear` = 1, then go to DONE. There is no timeout.
- **DONE:** Result registers are loaded on entry. `done` = 1 for this cycle only. Next state is IDLE.
- Results hold until the next `done`. They are not disturbed by a new `start` until that cycle's DONE.
- `error` is set under any of these conditions:
  - any valid beat outside COLLECT;
  - an X beat while xBeatCount == X_BINS, or the Y equivalent; the beat is ignored;
  - `start` while `busy`; the `start` is ignored.
- A peak count of 0 (empty histogram) yields index 0, count 0 and `found` = 0 when MIN_COUNT ≥ 1.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. Reset is honoured asynchronously in any state, aborting the cycle with no clear issued.
- **Read request:** `start` sampled high at edge k → `readHistogram` is high in cycle k+1.
- **First beat:** the earliest beat accepted is at edge k+2.
- **Clear request:** the last required beat at edge m → `clearHistogram` is high in cycle m+1.
- **Done:** `histogramClear` sampled at edge p → `done` and the new results appear in cycle p+1.
- **Minimum latency** with a back-to-back producer, from `start` to `done`: max(X_BINS, Y_BINS) + 4 cycles plus the acknowledge delay.
- **Same-cycle restart:** `start` in the `done` cycle is ignored and flags `error`. `start` one cycle later is accepted.
- **Registering:** all outputs are registered. There are no combinational paths from input to output.

## Structure
- **Shared package `histogram_pkg`:** X_BINS/Y_BINS defaults, COUNT_W, IDX_W and the FSM state encoding. This is shared with computeHistogram.
- **Sub-module `peak_tracker` (instantiated twice, X and Y):** parameters BINS, COUNT_W, IDX_W.
  - Inputs: `clk`, `reset`, `init`, `valid`, `value`, `enable`.
  - Outputs: `maxCount`, `maxIndex`, `full` (beat count == BINS), `overrun`.
- The top level holds the FSM, request pulses, result registers and error logic.

## Test plan
- **Ramp:** X bins = i, Y bins = 179−i, sequential streams → xPeakIndex = 239, xPeakCount = 239, yPeakIndex = 0, yPeakCount = 179, `found` = 1, and exactly one `readHistogram` pulse and one `clearHistogram` pulse.
- **Ties:** X bins 10 and 200 both = 50, all others 3; Y bin 90 = 7, interleaved and simultaneous beats → xPeakIndex = 10, yPeakIndex = 90.
- **All-zero histogram** → counts 0, indices 0, `found` = 0, `done` pulses once.
- **Protocol errors:** a 241st xValid beat, `start` while `busy` and a beat in IDLE → `error` = 1, results unaffected. The next `start` clears `error`.
- **Delayed acknowledge:** hold `histogramClear` low for 20 cycles → FSM stays in WAIT_CLR, `done` appears exactly one cycle after the acknowledge.
- **Reset during COLLECT** after 100 beats → all outputs 0 immediately. A following full run produces correct results.
